pc_gen: RTL and testbench

//  Next-generation fetch PC generator for the IF stage. Holds the fetch PC, steps it by a configurable

---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_gen_btb.sv | 84 ++++++++
 rtl/pc_gen.sv | 143 ++++++++++++++
 tb/tb_pc_gen.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the fetch PC generator.
// Optional feature macro used by this slice: PC_BTB_EN (branch target buffer).
package pc_gen_pkg;

  // Value of stall_i[0] that freezes the IF stage.
  localparam logic STOP = 1'b1;

  // Fetch sequencer states: reset hold, one boot cycle with an empty pipe, then normal fetch.
  typedef enum logic [1:0] {
    PC_S_RESET = 2'd0,
    PC_S_BOOT  = 2'd1,
    PC_S_RUN   = 2'd2
  } pc_state_e;

endpackage

// File: rtl/pc_gen_btb.sv
// Direct-mapped branch target buffer for pc_gen (instantiated only with PC_BTB_EN).
// Lookup is combinational on the current fetch PC; updates land at the next clock edge,
// so a same-cycle update and lookup of one index see the old entry.
module pc_gen_btb
  import pc_gen_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int STEP_LSB   = 2,
  parameter int ENTRIES    = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [ADDR_WIDTH-1:0] lookup_pc_i,
  output logic                  hit_o,
  output logic [ADDR_WIDTH-1:0] tgt_o,
  input  logic                  upd_i,
  input  logic [ADDR_WIDTH-1:0] upd_src_i,
  input  logic [ADDR_WIDTH-1:0] upd_tgt_i
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LSB = STEP_LSB + IDX_W;
  localparam int TAG_W = ADDR_WIDTH - TAG_LSB;

  logic                  valid_q [ENTRIES];
  logic                  valid_d [ENTRIES];
  logic [TAG_W-1:0]      tag_q   [ENTRIES];
  logic [TAG_W-1:0]      tag_d   [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgt_q   [ENTRIES];
  logic [ADDR_WIDTH-1:0] tgt_d   [ENTRIES];

  logic [IDX_W-1:0] rd_idx_s;
  logic [TAG_W-1:0] rd_tag_s;
  logic [IDX_W-1:0] wr_idx_s;
  logic             unused_low_bits_s;

  // Byte-offset bits never take part in index or tag.
  assign unused_low_bits_s = ^{lookup_pc_i[STEP_LSB-1:0], upd_src_i[STEP_LSB-1:0]};

  assign rd_idx_s = lookup_pc_i[STEP_LSB +: IDX_W];
  assign rd_tag_s = lookup_pc_i[ADDR_WIDTH-1:TAG_LSB];
  assign wr_idx_s = upd_src_i[STEP_LSB +: IDX_W];

  // Lookup: a hit needs a valid entry whose stored tag matches the fetch PC's upper bits.
  always_comb begin
    hit_o = 1'b0;
    tgt_o = tgt_q[rd_idx_s];
    if (valid_q[rd_idx_s] && (tag_q[rd_idx_s] == rd_tag_s)) begin
      hit_o = 1'b1;
    end else begin
      hit_o = 1'b0;
    end
  end

  // Update: overwrite the indexed entry with the new branch's tag and target.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    if (upd_i) begin
      valid_d[wr_idx_s] = 1'b1;
      tag_d[wr_idx_s]   = upd_src_i[ADDR_WIDTH-1:TAG_LSB];
      tgt_d[wr_idx_s]   = upd_tgt_i;
    end else begin
      valid_d = valid_q;
    end
  end

  // Entry storage; reset invalidates every entry.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator for the IF stage: sequential stepping, prioritised trap/jump
// redirects, and a req/gnt handshake (request = ce_o & ~stall_i[0]).
// Define PC_BTB_EN to add a direct-mapped BTB that predicts the sequential next PC.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int          PC_STEP      = 4,
  parameter int          STALL_WIDTH  = 6,
  parameter int          BTB_ENTRIES  = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [STALL_WIDTH-1:0] stall_i,
  input  logic                   flush_int_i,
  input  logic [ADDR_WIDTH-1:0]  int_pc_i,
  input  logic                   flush_jump_i,
  input  logic [ADDR_WIDTH-1:0]  jump_pc_i,
  input  logic                   gnt_i,
`ifdef PC_BTB_EN
  input  logic                   btb_upd_i,
  input  logic [ADDR_WIDTH-1:0]  btb_src_i,
  input  logic [ADDR_WIDTH-1:0]  btb_tgt_i,
`endif
  output logic [ADDR_WIDTH-1:0]  pc_o,
  output logic                   ce_o,
  output logic                   misalign_o
);

  localparam int STEP_LSB = $clog2(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] STEP_V   = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(PC_STEP - 1);
  localparam logic [ADDR_WIDTH-1:0] RST_PC   = ADDR_WIDTH'(RESET_VECTOR);

  pc_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                  ce_q, ce_d;
  logic                  misalign_q, misalign_d;

  logic                  redir_s;
  logic [ADDR_WIDTH-1:0] redir_tgt_s;
  logic                  btb_hit_s;
  logic [ADDR_WIDTH-1:0] btb_tgt_s;
  logic                  unused_stall_s;

  // Only the IF bit of the stall vector matters here.
  assign unused_stall_s = ^stall_i[STALL_WIDTH-1:1];

`ifdef PC_BTB_EN
  pc_gen_btb #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .STEP_LSB   (STEP_LSB),
    .ENTRIES    (BTB_ENTRIES)
  ) u_btb (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .lookup_pc_i (pc_q),
    .hit_o       (btb_hit_s),
    .tgt_o       (btb_tgt_s),
    .upd_i       (btb_upd_i),
    .upd_src_i   (btb_src_i),
    .upd_tgt_i   (btb_tgt_i)
  );
`else
  localparam int unused_btb_entries_p = BTB_ENTRIES;
  assign btb_hit_s = 1'b0;
  assign btb_tgt_s = '0;
`endif

  // Redirect select: trap beats jump; neither depends on grant or stall.
  always_comb begin
    redir_s     = 1'b0;
    redir_tgt_s = '0;
    if (flush_int_i) begin
      redir_s     = 1'b1;
      redir_tgt_s = int_pc_i;
    end else if (flush_jump_i) begin
      redir_s     = 1'b1;
      redir_tgt_s = jump_pc_i;
    end else begin
      redir_s     = 1'b0;
      redir_tgt_s = '0;
    end
  end

  // Sequencer and next-PC selection; misaligned redirect targets are forced to step alignment.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    misalign_d = 1'b0;
    case (state_q)
      PC_S_RESET: begin
        state_d = PC_S_BOOT;
        pc_d    = RST_PC;
      end
      PC_S_BOOT: begin
        state_d = PC_S_RUN;
        pc_d    = RST_PC;
      end
      PC_S_RUN: begin
        state_d = PC_S_RUN;
        if (redir_s) begin
          pc_d       = redir_tgt_s & ~LOW_MASK;
          misalign_d = |(redir_tgt_s & LOW_MASK);
        end else if (stall_i[0] == STOP) begin
          pc_d = pc_q;
        end else if (!gnt_i) begin
          pc_d = pc_q;
        end else if (btb_hit_s) begin
          pc_d = btb_tgt_s;
        end else begin
          pc_d = pc_q + STEP_V;
        end
      end
      default: begin
        state_d = PC_S_RESET;
        pc_d    = RST_PC;
      end
    endcase
    ce_d = (state_d == PC_S_RUN);
  end

  // State, PC and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= PC_S_RESET;
      pc_q       <= RST_PC;
      ce_q       <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ce_q       <= ce_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign ce_o       = ce_q;
  assign misalign_o = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed scenarios followed by randomized traffic,
// all checked against a cycle-level reference model of the fetch rules.
module tb_pc_gen;

  localparam int          AW    = 32;
  localparam logic [31:0] RV    = 32'h0000_0100;
  localparam int          STEP  = 4;
  localparam int          SW    = 6;
  localparam int          ENT   = 8;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [SW-1:0] stall_i;
  logic          flush_int_i;
  logic [AW-1:0] int_pc_i;
  logic          flush_jump_i;
  logic [AW-1:0] jump_pc_i;
  logic          gnt_i;
`ifdef PC_BTB_EN
  logic          btb_upd_i;
  logic [AW-1:0] btb_src_i;
  logic [AW-1:0] btb_tgt_i;
`endif
  logic [AW-1:0] pc_o;
  logic          ce_o;
  logic          misalign_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: cycles since reset release (0,1 then 2 = fetching), PC, pulse.
  int          m_phase;
  logic [31:0] m_pc;
  logic        m_mis;
  bit          mb_valid [ENT];
  logic [31:0] mb_src   [ENT];
  logic [31:0] mb_tgt   [ENT];

  pc_gen #(
    .ADDR_WIDTH   (AW),
    .RESET_VECTOR (RV),
    .PC_STEP      (STEP),
    .STALL_WIDTH  (SW),
    .BTB_ENTRIES  (ENT)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .stall_i      (stall_i),
    .flush_int_i  (flush_int_i),
    .int_pc_i     (int_pc_i),
    .flush_jump_i (flush_jump_i),
    .jump_pc_i    (jump_pc_i),
    .gnt_i        (gnt_i),
`ifdef PC_BTB_EN
    .btb_upd_i    (btb_upd_i),
    .btb_src_i    (btb_src_i),
    .btb_tgt_i    (btb_tgt_i),
`endif
    .pc_o         (pc_o),
    .ce_o         (ce_o),
    .misalign_o   (misalign_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, "_pc"}, pc_o, m_pc);
    chk({tag, "_ce"}, {31'd0, ce_o}, {31'd0, (m_phase == 2)});
    chk({tag, "_mis"}, {31'd0, misalign_o}, {31'd0, m_mis});
  endtask

  task automatic idle_inputs();
    stall_i      = '0;
    flush_int_i  = 1'b0;
    int_pc_i     = '0;
    flush_jump_i = 1'b0;
    jump_pc_i    = '0;
    gnt_i        = 1'b1;
`ifdef PC_BTB_EN
    btb_upd_i    = 1'b0;
    btb_src_i    = '0;
    btb_tgt_i    = '0;
`endif
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_pc    = RV;
    m_mis   = 1'b0;
    for (int i = 0; i < ENT; i++) mb_valid[i] = 1'b0;
  endtask

  // One clock: predict from the inputs now applied, advance, then compare.
  task automatic tick(input string tag);
    logic [31:0] n_pc;
    logic [31:0] tgt;
    logic        n_mis;
    int          n_phase;
    int          idx;
    n_pc    = m_pc;
    n_mis   = 1'b0;
    n_phase = m_phase;
    if (m_phase < 2) begin
      n_phase = m_phase + 1;
      n_pc    = RV;
    end else if (flush_int_i || flush_jump_i) begin
      tgt   = flush_int_i ? int_pc_i : jump_pc_i;
      n_pc  = tgt - (tgt % STEP);
      n_mis = (tgt % STEP) != 0;
    end else if (stall_i[0] || !gnt_i) begin
      n_pc = m_pc;
    end else begin
      n_pc = m_pc + STEP;
`ifdef PC_BTB_EN
      idx = int'((m_pc / STEP) % ENT);
      if (mb_valid[idx] && ((mb_src[idx] / (STEP * ENT)) == (m_pc / (STEP * ENT))))
        n_pc = mb_tgt[idx];
`endif
    end
`ifdef PC_BTB_EN
    if (btb_upd_i) begin
      idx = int'((btb_src_i / STEP) % ENT);
      mb_valid[idx] = 1'b1;
      mb_src[idx]   = btb_src_i;
      mb_tgt[idx]   = btb_tgt_i;
    end
`endif
    @(posedge clk_i);
    #1;
    m_phase = n_phase;
    m_pc    = n_pc;
    m_mis   = n_mis;
    chk_model(tag);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    model_reset();
    chk_model("async_rst");
    @(posedge clk_i);
    #1;
    chk_model("rst_hold");
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk_model("reset");
    rst_i = 1'b0;

    // Reset release: boot cycle at the vector, then sequential fetch.
    tick("boot");
    chk("boot_ce_const", {31'd0, ce_o}, 32'd0);
    tick("run0");
    chk("run0_pc_const", pc_o, 32'h100);
    tick("run1");
    chk("run1_pc_const", pc_o, 32'h104);
    tick("run2");
    chk("run2_pc_const", pc_o, 32'h108);

    // No grant: address and request held.
    flush_jump_i = 1'b1; jump_pc_i = 32'h20;
    tick("jmp20");
    flush_jump_i = 1'b0;
    gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick("nognt");
      chk("nognt_pc_const", pc_o, 32'h20);
    end
    gnt_i = 1'b1;
    tick("gnt");
    chk("gnt_pc_const", pc_o, 32'h24);

    // Trap beats jump, and both override a stall.
    stall_i = 6'b000001;
    flush_int_i = 1'b1; int_pc_i = 32'h80;
    flush_jump_i = 1'b1; jump_pc_i = 32'h40;
    tick("int_vs_jmp");
    chk("int_vs_jmp_const", pc_o, 32'h80);
    idle_inputs();
    stall_i = 6'b000001;
    tick("stalled");
    idle_inputs();

    // Misaligned jump target: aligned load plus a single-cycle pulse.
    flush_jump_i = 1'b1; jump_pc_i = 32'h4A;
    tick("misal");
    chk("misal_pc_const", pc_o, 32'h48);
    chk("misal_pulse_const", {31'd0, misalign_o}, 32'd1);
    flush_jump_i = 1'b0;
    tick("misal_end");
    chk("misal_end_const", {31'd0, misalign_o}, 32'd0);

    // Top of the address space wraps to zero.
    flush_jump_i = 1'b1; jump_pc_i = 32'hFFFF_FFFC;
    tick("wrap_set");
    flush_jump_i = 1'b0;
    tick("wrap");
    chk("wrap_pc_const", pc_o, 32'h0);

    // BTB prediction at 0x10 (plain increment when the BTB is not built).
`ifdef PC_BTB_EN
    btb_upd_i = 1'b1; btb_src_i = 32'h10; btb_tgt_i = 32'h200;
`endif
    flush_jump_i = 1'b1; jump_pc_i = 32'h10;
    tick("btb_set");
    idle_inputs();
    tick("btb_use");
`ifdef PC_BTB_EN
    chk("btb_use_const", pc_o, 32'h200);
`else
    chk("btb_use_const", pc_o, 32'h14);
`endif

    // Reset in the middle of fetching.
    do_reset();
    tick("re_boot");
    tick("re_run");

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 199) == 0) begin
        idle_inputs();
        do_reset();
      end
      stall_i      = {5'($urandom), ($urandom_range(0, 3) == 0)};
      gnt_i        = ($urandom_range(0, 3) != 0);
      flush_int_i  = ($urandom_range(0, 15) == 0);
      int_pc_i     = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 255);
      flush_jump_i = ($urandom_range(0, 7) == 0);
      jump_pc_i    = ($urandom_range(0, 15) == 0) ? $urandom : $urandom_range(0, 255);
`ifdef PC_BTB_EN
      btb_upd_i    = ($urandom_range(0, 3) == 0);
      btb_src_i    = $urandom_range(0, 255) & 32'hFFFF_FFFC;
      btb_tgt_i    = $urandom_range(0, 255) & 32'hFFFF_FFFC;
`endif
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
